// File: rtl/aes_round_iter.sv
// aes_round_iter: iterative AES encryption round sequencer around an external round transform.
// Define ROUND_ITER_ABORT_EN to add abort_i, which cancels an operation in flight.
module aes_round_iter_lane #(
  parameter int VEC_W = 32
) (
  input  logic [1:0]       sel,
  input  logic [VEC_W-1:0] blk,
  input  logic [VEC_W-1:0] mc,
  input  logic [VEC_W-1:0] sr,
  input  logic [VEC_W-1:0] rk,
  output logic [VEC_W-1:0] q
);
  logic [VEC_W-1:0] src;

  always_comb begin
    src = blk;
    case (sel)
      2'd1:    src = mc;
      2'd2:    src = sr;
      default: src = blk;
    endcase
  end

  assign q = src ^ rk;
endmodule

module aes_round_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef ROUND_ITER_ABORT_EN
  input  logic         abort_i,
`endif
  input  logic         start_i,
  input  logic [127:0] block_i,
  output logic [3:0]   rk_idx_o,
  input  logic [127:0] rk_i,
  output logic         rtf_start_o,
  output logic [127:0] rtf_s_o,
  input  logic [127:0] rtf_sr_i,
  input  logic [127:0] rtf_mc_i,
  input  logic         rtf_done_i,
  output logic         busy_o,
  output logic [127:0] ct_o,
  output logic         done_o
);
  localparam int         NUM_LANES = 4;
  localparam int         VEC_W     = 32;
  localparam logic [3:0] NR_L      = 4'(NR);
  localparam logic [1:0] SRC_BLK   = 2'd0;
  localparam logic [1:0] SRC_MC    = 2'd1;
  localparam logic [1:0] SRC_SR    = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, KICK = 2'd1, WAIT = 2'd2} state_t;

  state_t       state;
  logic [127:0] st;
  logic [3:0]   rnd;
  logic         last;
  logic         abort_hit;
  logic [1:0]   src_sel;

  logic [NUM_LANES-1:0][VEC_W-1:0] blk_l, mc_l, sr_l, rk_l, nxt_l;
  logic [127:0]                    nxt;

`ifdef ROUND_ITER_ABORT_EN
  assign abort_hit = abort_i && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign last = (rnd == NR_L);

  // One shared XOR datapath: block on accept, MixColumns mid-run, ShiftRows tap on the last round.
  always_comb begin
    src_sel = SRC_BLK;
    if (state == WAIT) src_sel = last ? SRC_SR : SRC_MC;
  end

  assign blk_l = block_i;
  assign mc_l  = rtf_mc_i;
  assign sr_l  = rtf_sr_i;
  assign rk_l  = rk_i;
  assign nxt   = nxt_l;

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      aes_round_iter_lane #(.VEC_W(VEC_W)) u_lane (
        .sel (src_sel),
        .blk (blk_l[g]),
        .mc  (mc_l[g]),
        .sr  (sr_l[g]),
        .rk  (rk_l[g]),
        .q   (nxt_l[g])
      );
    end
  endgenerate

  assign rk_idx_o = (state == IDLE) ? 4'd0 : rnd;
  assign rtf_s_o  = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      st          <= '0;
      rnd         <= '0;
      ct_o        <= '0;
      done_o      <= 1'b0;
      busy_o      <= 1'b0;
      rtf_start_o <= 1'b0;
    end else begin
      rtf_start_o <= 1'b0;
      done_o      <= 1'b0;
      if (abort_hit) begin
        state  <= IDLE;
        rnd    <= '0;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // busy_o stays up through the done_o cycle and drops with it unless restarted
            busy_o <= start_i;
            if (start_i) begin
              st          <= nxt;
              rnd         <= 4'd1;
              rtf_start_o <= 1'b1;
              state       <= KICK;
            end
          end
          KICK: state <= WAIT;
          WAIT: begin
            if (rtf_done_i) begin
              if (!last) begin
                st          <= nxt;
                rnd         <= rnd + 4'd1;
                rtf_start_o <= 1'b1;
                state       <= KICK;
              end else begin
                ct_o   <= nxt;
                done_o <= 1'b1;
                state  <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_aes_round_iter.sv
// Directed bench for aes_round_iter: FIPS-197 C.1 vector through a behavioural round transform.
module tb_aes_round_iter;
  localparam int           NR  = 10;
  localparam int           L   = 4;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic         clk, rst_n, start_i;
  logic [127:0] block_i, rk_i, rtf_s_o, rtf_sr_i, rtf_mc_i, ct_o;
  logic [3:0]   rk_idx_o;
  logic         rtf_start_o, rtf_done_i, busy_o, done_o;
`ifdef ROUND_ITER_ABORT_EN
  logic         abort_i;
`endif

  logic [127:0] rk_tab [16];
  logic [127:0] m_s;
  int           m_cnt;
  logic         m_done, spur;
  int           total, bad;
  int           n_kick, n_done;
  logic [3:0]   trace [$];

  aes_round_iter #(.NR(NR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef ROUND_ITER_ABORT_EN
    .abort_i     (abort_i),
`endif
    .start_i     (start_i),
    .block_i     (block_i),
    .rk_idx_o    (rk_idx_o),
    .rk_i        (rk_i),
    .rtf_start_o (rtf_start_o),
    .rtf_s_o     (rtf_s_o),
    .rtf_sr_i    (rtf_sr_i),
    .rtf_mc_i    (rtf_mc_i),
    .rtf_done_i  (rtf_done_i),
    .busy_o      (busy_o),
    .ct_o        (ct_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int b = 0; b < 16; b++) o[127-8*b -: 8] = sb(s[127-8*b -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];    a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];    a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  // Combinational key store and behavioural round transform with fixed latency L.
  assign rk_i       = rk_tab[rk_idx_o];
  assign rtf_sr_i   = shift_rows(sub_bytes(m_s));
  assign rtf_mc_i   = mix_cols(rtf_sr_i);
  assign rtf_done_i = m_done | spur;

  always @(negedge clk) begin
    m_done = 1'b0;
    if (!rst_n) m_cnt = 0;
    else if (rtf_start_o) begin
      m_s   = rtf_s_o;
      m_cnt = L;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rtf_start_o) n_kick++;
    if (done_o) n_done++;
    if (trace.size() == 0 || trace[trace.size()-1] !== rk_idx_o) trace.push_back(rk_idx_o);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input bit hold, input logic [15:0] smask, output int lat, output bit found);
    int kick;
    kick = 0; lat = 0; found = 1'b0;
    @(negedge clk);
    start_i = 1'b1;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!hold) start_i = 1'b0;
      if (rtf_start_o) kick++;
      spur = rtf_start_o && smask[kick];
      if (done_o) found = 1'b1;
    end
    start_i = 1'b0;
    spur    = 1'b0;
  endtask

  initial begin
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rcon;
    int           lat, d0, k0, base, errs;
    bit           found;

    total = 0; bad = 0; n_kick = 0; n_done = 0;
    m_cnt = 0; m_done = 1'b0; m_s = '0;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;

    rst_n = 1'b0; start_i = 1'b0; spur = 1'b0; block_i = PT;
`ifdef ROUND_ITER_ABORT_EN
    abort_i = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_kick", rtf_start_o, 0);
    chk("rst_idx", rk_idx_o, 0);
    chk("rst_ct", ct_o, 0);
    chk("rst_st", rtf_s_o, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single C.1 encryption and its latency
    d0 = n_done;
    run_op(1'b0, 16'h0, lat, found);
    chk("c1_found", found, 1);
    chk("c1_ct", ct_o, CT);
    chk("c1_lat", lat, 51);
    chk("c1_busy_at_done", busy_o, 1);
    @(negedge clk);
    chk("c1_done_fall", done_o, 0);
    chk("c1_busy_fall", busy_o, 0);
    chk("c1_idx_idle", rk_idx_o, 0);
    chk("c1_ct_hold", ct_o, CT);
    chk("c1_done_cnt", n_done - d0, 1);

    // back-to-back: second start right in the cycle after done_o
    d0 = n_done;
    run_op(1'b0, 16'h0, lat, found);
    chk("b2b1_ct", ct_o, CT);
    chk("b2b1_lat", lat, 51);
    run_op(1'b0, 16'h0, lat, found);
    chk("b2b2_ct", ct_o, CT);
    chk("b2b2_lat", lat, 51);
    repeat (5) @(negedge clk);
    chk("b2b_done_cnt", n_done - d0, 2);

    // start_i held high for the whole operation
    d0 = n_done; k0 = n_kick; base = trace.size();
    run_op(1'b1, 16'h0, lat, found);
    chk("hold_ct", ct_o, CT);
    repeat (60) @(negedge clk);
    chk("hold_done_cnt", n_done - d0, 1);
    chk("hold_kick_cnt", n_kick - k0, NR);
    chk("hold_busy", busy_o, 0);
    errs = 0;
    if (base < 1 || trace[base-1] !== 4'd0) errs++;
    if (trace.size() != base + NR + 1) errs++;
    else begin
      for (int j = 0; j < NR; j++) if (trace[base+j] !== 4'(j+1)) errs++;
      if (trace[base+NR] !== 4'd0) errs++;
    end
    chk("hold_idx_seq_errs", errs, 0);

    // spurious done pulses during the KICK cycles of rounds 1 and 5, then in IDLE
    run_op(1'b0, 16'h0022, lat, found);
    chk("spur_ct", ct_o, CT);
    chk("spur_lat", lat, 51);
    repeat (3) @(negedge clk);
    d0 = n_done;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("spur_idle_busy", busy_o, 0);
    chk("spur_idle_kick", rtf_start_o, 0);
    chk("spur_idle_done_cnt", n_done - d0, 0);
    chk("spur_idle_ct", ct_o, CT);

    // asynchronous reset in the WAIT of round 5
    @(negedge clk);
    start_i = 1'b1;
    k0 = n_kick;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (rtf_start_o && n_kick - k0 >= 4) break;
    end
    @(negedge clk);
    chk("mid_busy_pre", busy_o, 1);
    chk("mid_idx_pre", rk_idx_o, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_ct", ct_o, 0);
    chk("arst_st", rtf_s_o, 0);
    chk("arst_idx", rk_idx_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_kick", rtf_start_o, 0);
    d0 = n_done;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst_no_done", n_done - d0, 0);
    run_op(1'b0, 16'h0, lat, found);
    chk("arst_rerun_ct", ct_o, CT);
    chk("arst_rerun_lat", lat, 51);

`ifdef ROUND_ITER_ABORT_EN
    // abort in the WAIT of round 3; the stale done from that round must be ignored
    repeat (2) @(negedge clk);
    start_i = 1'b1;
    k0 = n_kick;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (rtf_start_o && n_kick - k0 >= 2) break;
    end
    @(negedge clk);
    d0 = n_done;
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_idx", rk_idx_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_ct_hold", ct_o, CT);
    repeat (10) @(negedge clk);
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_still_idle", busy_o, 0);
    run_op(1'b0, 16'h0, lat, found);
    chk("abort_rerun_ct", ct_o, CT);
    chk("abort_rerun_lat", lat, 51);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_round_iter.md
# aes_round_iter

Iterative AES-encryption round sequencer. It wraps the round transform stage, which performs SubBytes, ShiftRows and MixColumns. This block performs the initial AddRoundKey, starts one round transform per round and XORs the returned state with the round key. For the final round it selects the ShiftRows-only tap, so MixColumns is skipped. It sits between the block-level input/output handshake and the round transform, and pulls round keys from an external key-schedule store by index.

## Interface
Parameters:
- NR, default 10, number of rounds; legal values are 10, 12 and 14.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start_i  in  1  start request; accepted only in IDLE.
- block_i  in  128  plaintext; sampled in the accept cycle.
- rk_idx_o  out  4  round-key index driven to the key store.
- rk_i  in  128  round key for rk_idx_o, valid in the same cycle (combinational store).
- rtf_start_o  out  1  one-cycle start pulse to the round transform.
- rtf_s_o  out  128  state to the round transform; equals the internal state register.
- rtf_sr_i  in  128  ShiftRows tap returned by the round transform.
- rtf_mc_i  in  128  MixColumns output returned by the round transform.
- rtf_done_i  in  1  round transform done pulse.
- busy_o  out  1  high from the accept cycle +1 until done_o.
- ct_o  out  128  ciphertext; holds its value until the next completion.
- done_o  out  1  one-cycle completion pulse, coincident with ct_o update.

## Operation
- State register st (128 bits), round counter rnd (4 bits), FSM with states IDLE, KICK and WAIT.
- IDLE: rk_idx_o = 0. When start_i=1:
  - st <= block_i ^ rk_i
  - rnd <= 1
  - go to KICK.
- KICK:
  - rk_idx_o = rnd
  - rtf_start_o = 1 for exactly this cycle
  - go to WAIT.
- WAIT: rk_idx_o = rnd. When rtf_done_i=1:
  - if rnd < NR: st <= rtf_mc_i ^ rk_i, rnd <= rnd+1, go to KICK.
  - if rnd == NR: ct_o <= rtf_sr_i ^ rk_i, done_o <= 1 for one cycle, go to IDLE.
- start_i outside IDLE is ignored; it is not queued.
- rtf_done_i outside WAIT is ignored.
- All XORs are bitwise across 128 bits; byte order matches the round transform (bits [127:120] are byte 0).
- rnd never exceeds NR and does not wrap.

## Timing
- Reset values:
  - FSM = IDLE
  - st = 0, rnd = 0, ct_o = 0
  - done_o = 0, busy_o = 0, rtf_start_o = 0
  - rk_idx_o = 0.
- Reset asserted mid-operation: return to IDLE immediately (asynchronous clear); no done_o is produced.
- Round transform latency L is the number of cycles from rtf_start_o to rtf_done_i (L ≥ 1).
- Per round: 1 KICK cycle + L cycles.
- Total latency, accept edge to done_o high: 1 + NR·(1+L) cycles.
- done_o and busy_o fall together. A new start_i is accepted in the cycle after done_o.
- rtf_s_o is stable from KICK through rtf_done_i. The round transform samples it on rtf_start_o.
- rk_i must be stable while rk_idx_o is constant; this block samples it only in the accept cycle and in the done cycle.

## Configuration
- ROUND_ITER_ABORT_EN defined:
  - adds input abort_i (1 bit).
  - abort_i=1 in KICK or WAIT returns the FSM to IDLE at the next edge and clears rnd.
  - no done_o is produced and ct_o is unchanged.
  - a later rtf_done_i from the aborted round is ignored.
  - abort_i in IDLE has no effect; abort_i and start_i together in IDLE mean start wins.
- ROUND_ITER_ABORT_EN undefined: the abort_i port and its logic are absent; behaviour is otherwise identical.

## Test plan
- FIPS-197 C.1, NR=10:
  - stimulus: block_i=00112233445566778899aabbccddeeff, key store built from key 000102030405060708090a0b0c0d0e0f, reference round-transform model with L=4.
  - required response: ct_o=69c4e0d86a7b0430d8cdb78070b4c55a; done_o high exactly 51 cycles after the accept edge.
- Back-to-back operation:
  - stimulus: assert start_i in the cycle after done_o, twice, with the C.1 vector.
  - required response: both ct_o values are correct; exactly two done_o pulses; no idle gap beyond one cycle.
- start_i held high while busy:
  - required response: exactly one operation; rtf_start_o count = NR; rk_idx_o sequence 0, 1, …, NR.
- Spurious rtf_done_i injected in KICK and IDLE:
  - required response: no state change; ct_o is still correct.
- rst_n pulsed low at round 5 (mid-WAIT):
  - required response: all outputs go to reset values asynchronously.
  - a following C.1 run gives the correct ct_o.
- With ROUND_ITER_ABORT_EN: abort_i at round 3.
  - required response: IDLE next cycle; no done_o; ct_o keeps its previous value; the next run is correct.
